// File: rtl/proximity_alarm_ctrl.sv
// Proximity alarm controller: tracks the per-frame disparity maximum inside a column window,
// runs a hysteresis alarm FSM on it, and arbitrates a tone generator between alarm and beeps.
module proximity_alarm_ctrl #(
  parameter int unsigned H_RES       = 160,
  parameter int unsigned FRAME_LAST  = 19199,
  parameter int unsigned ON_THRESH   = 128,
  parameter int unsigned OFF_THRESH  = 96,
  parameter int unsigned ON_FRAMES   = 3,
  parameter int unsigned OFF_FRAMES  = 5,
  parameter int unsigned BEEP_PERIOD = 200000,
  parameter int unsigned BEEP_FRAMES = 4
) (
  input  logic        clk_data,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [14:0] pix_addr,
  input  logic [7:0]  pix_data,
  input  logic [7:0]  roi_x0,
  input  logic [7:0]  roi_x1,
  input  logic        beep_req,
  output logic        beep_ack,
  output logic        frame_done,
  output logic [7:0]  frame_max,
  output logic        alarm,
  output logic        tone_en,
  output logic [19:0] tone_period
);

  localparam logic [14:0] LastAddr = 15'(FRAME_LAST);
  localparam logic [7:0]  ColLast  = 8'(H_RES - 1);
  localparam logic [7:0]  OnTh     = 8'(ON_THRESH);
  localparam logic [7:0]  OffTh    = 8'(OFF_THRESH);
  localparam logic [2:0]  OnCnt    = 3'(ON_FRAMES);
  localparam logic [2:0]  OffCnt   = 3'(OFF_FRAMES);
  localparam logic [2:0]  BeepCnt  = 3'(BEEP_FRAMES);
  localparam logic [19:0] BeepPer  = 20'(BEEP_PERIOD);
  localparam logic [19:0] PerBase  = 20'd520000;

  typedef enum logic [1:0] {StIdle, StArming, StAlarm, StReleasing} state_e;

  // Pixel path
  logic [7:0] col_q, col_d, x0_q, x0_d, x1_q, x1_d, max_q, max_d, frame_max_q;
  logic       in_frame_q, in_frame_d, in_roi, is_first, done_d, done_q;

  always_comb begin
    is_first = (pix_addr == 15'd0);
    if (is_first) begin
      col_d = 8'd0;
      x0_d  = roi_x0;
      x1_d  = roi_x1;
    end else begin
      col_d = (col_q == ColLast) ? 8'd0 : col_q + 8'd1;
      x0_d  = x0_q;
      x1_d  = x1_q;
    end
    in_roi = (x0_d <= col_d) && (col_d <= x1_d);
    if (is_first) begin
      max_d = in_roi ? pix_data : 8'd0;
    end else if (in_roi && (pix_data > max_q)) begin
      max_d = pix_data;
    end else begin
      max_d = max_q;
    end
    // Only a frame that began at address 0 may complete; aborted or post-reset tails are dropped.
    in_frame_d = (pix_addr != LastAddr) && (is_first || in_frame_q);
    done_d     = pix_valid && (pix_addr == LastAddr) && (is_first || in_frame_q);
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= 8'd0;
      x0_q        <= 8'd0;
      x1_q        <= 8'd0;
      max_q       <= 8'd0;
      in_frame_q  <= 1'b0;
      done_q      <= 1'b0;
      frame_max_q <= 8'd0;
    end else begin
      done_q <= done_d;
      if (pix_valid) begin
        col_q      <= col_d;
        x0_q       <= x0_d;
        x1_q       <= x1_d;
        max_q      <= max_d;
        in_frame_q <= in_frame_d;
      end
      if (done_d) begin
        frame_max_q <= max_d;
      end
    end
  end

  // Alarm FSM
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d, cnt_inc;
  logic        is_near, is_clear, alarm_d, alarm_q;
  logic [19:0] alarm_period_q, alarm_period_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cnt_inc  = cnt_q + 3'd1;
    is_near  = (frame_max_q >= OnTh);
    is_clear = (frame_max_q < OffTh);
    if (done_q) begin
      case (state_q)
        StIdle: begin
          if (is_near) begin
            if (OnCnt <= 3'd1) begin
              state_d = StAlarm;
              cnt_d   = 3'd0;
            end else begin
              state_d = StArming;
              cnt_d   = 3'd1;
            end
          end
        end
        StArming: begin
          if (!is_near) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
          end else if (cnt_inc >= OnCnt) begin
            state_d = StAlarm;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StAlarm: begin
          if (is_clear) begin
            if (OffCnt <= 3'd1) begin
              state_d = StIdle;
              cnt_d   = 3'd0;
            end else begin
              state_d = StReleasing;
              cnt_d   = 3'd1;
            end
          end
        end
        StReleasing: begin
          if (!is_clear) begin
            state_d = StAlarm;
            cnt_d   = 3'd0;
          end else if (cnt_inc >= OffCnt) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 3'd0;
        end
      endcase
    end
    alarm_d        = (state_d == StAlarm) || (state_d == StReleasing);
    alarm_period_d = (done_q && alarm_d) ? PerBase - 20'(frame_max_q) * 20'd2000 : alarm_period_q;
  end

  // Beep arbitration: evaluated against the FSM's next state so the alarm always wins.
  logic        beep_active_q, beep_active_d, beep_ack_q, grant;
  logic [2:0]  beep_cnt_q, beep_cnt_d, beep_inc;
  logic        tone_en_q, tone_en_d;
  logic [19:0] tone_period_q, tone_period_d;

  always_comb begin
    beep_active_d = beep_active_q;
    beep_cnt_d    = beep_cnt_q;
    beep_inc      = beep_cnt_q + 3'd1;
    grant         = beep_req && !alarm_d && !alarm_q && !beep_active_q;
    if (alarm_d) begin
      beep_active_d = 1'b0;
    end else if (grant) begin
      beep_active_d = 1'b1;
      beep_cnt_d    = 3'd0;
    end else if (beep_active_q && done_q) begin
      if (beep_inc >= BeepCnt) begin
        beep_active_d = 1'b0;
      end
      beep_cnt_d = beep_inc;
    end
    tone_en_d = alarm_d | beep_active_d;
    if (alarm_d) begin
      tone_period_d = alarm_period_d;
    end else if (beep_active_d) begin
      tone_period_d = BeepPer;
    end else begin
      tone_period_d = tone_period_q;
    end
  end

  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= 3'd0;
      alarm_q        <= 1'b0;
      alarm_period_q <= PerBase;
      beep_active_q  <= 1'b0;
      beep_cnt_q     <= 3'd0;
      beep_ack_q     <= 1'b0;
      tone_en_q      <= 1'b0;
      tone_period_q  <= PerBase;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alarm_q        <= alarm_d;
      alarm_period_q <= alarm_period_d;
      beep_active_q  <= beep_active_d;
      beep_cnt_q     <= beep_cnt_d;
      beep_ack_q     <= grant;
      tone_en_q      <= tone_en_d;
      tone_period_q  <= tone_period_d;
    end
  end

  assign beep_ack    = beep_ack_q;
  assign frame_done  = done_q;
  assign frame_max   = frame_max_q;
  assign alarm       = alarm_q;
  assign tone_en     = tone_en_q;
  assign tone_period = tone_period_q;

endmodule

// File: tb/tb_proximity_alarm_ctrl.sv
// Scoreboard bench for proximity_alarm_ctrl using a reduced 16x4 frame geometry.
module tb_proximity_alarm_ctrl;

  localparam int HRes = 16, FrameLast = 63;
  localparam int OnTh = 128, OffTh = 96, OnFrames = 3, OffFrames = 5;

  logic        clk_data = 1'b0, rst_n = 1'b1, pix_valid = 1'b0, beep_req = 1'b0;
  logic [14:0] pix_addr = '0;
  logic [7:0]  pix_data = '0, roi_x0 = '0, roi_x1 = '0;
  logic        beep_ack, frame_done, alarm, tone_en;
  logic [7:0]  frame_max;
  logic [19:0] tone_period;

  always #5 clk_data = ~clk_data;

  proximity_alarm_ctrl #(
    .H_RES(HRes), .FRAME_LAST(FrameLast)
  ) dut (
    .clk_data(clk_data), .rst_n(rst_n), .pix_valid(pix_valid), .pix_addr(pix_addr),
    .pix_data(pix_data), .roi_x0(roi_x0), .roi_x1(roi_x1), .beep_req(beep_req),
    .beep_ack(beep_ack), .frame_done(frame_done), .frame_max(frame_max), .alarm(alarm),
    .tone_en(tone_en), .tone_period(tone_period)
  );

  typedef struct {logic [7:0] mx; bit alm;} exp_t;
  exp_t       exp_q[$];
  int         total = 0, bad = 0, done_cnt = 0, ack_cnt = 0;
  bit         m_alarm = 0;
  int         near_run = 0, clear_run = 0;
  logic [7:0] vals [0:FrameLast];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Alarm behaviour as streak counting: ON_FRAMES near in a row raises, OFF_FRAMES clear releases.
  task automatic model_frame(input int mx, output bit alm);
    if (!m_alarm) begin
      near_run = (mx >= OnTh) ? near_run + 1 : 0;
      if (near_run >= OnFrames) begin m_alarm = 1; near_run = 0; end
    end else begin
      clear_run = (mx < OffTh) ? clear_run + 1 : 0;
      if (clear_run >= OffFrames) begin m_alarm = 0; clear_run = 0; end
    end
    alm = m_alarm;
  endtask

  task automatic fill(input int base, input int peak, input int pos, input bit rnd);
    for (int a = 0; a <= FrameLast; a++) vals[a] = rnd ? 8'($urandom_range(0, base)) : 8'(base);
    vals[pos] = 8'(peak);
  endtask

  task automatic drive_pixel(input int addr, input logic [7:0] d, input logic [7:0] x0,
                             input logic [7:0] x1);
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 2)) begin
        @(negedge clk_data);
        pix_valid = 1'b0;
        pix_addr  = 15'($urandom_range(0, FrameLast));
        pix_data  = 8'($urandom);
      end
    end
    @(negedge clk_data);
    pix_valid = 1'b1;
    pix_addr  = 15'(addr);
    pix_data  = d;
    if (addr == 0) begin roi_x0 = x0; roi_x1 = x1; end
    else begin roi_x0 = 8'($urandom); roi_x1 = 8'($urandom); end
  endtask

  // Ends at the sample point just after the edge that captures the last pixel.
  task automatic send_range(input int first, input int last, input logic [7:0] x0,
                            input logic [7:0] x1);
    for (int a = first; a <= last; a++) drive_pixel(a, vals[a], x0, x1);
    @(posedge clk_data);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] x0, input logic [7:0] x1);
    exp_t e;
    int   mx = 0;
    for (int a = 0; a <= FrameLast; a++)
      if (x0 <= 8'(a % HRes) && 8'(a % HRes) <= x1 && int'(vals[a]) > mx) mx = vals[a];
    e.mx = 8'(mx);
    model_frame(mx, e.alm);
    exp_q.push_back(e);
    send_range(0, FrameLast, x0, x1);
    check("frame_done_latency", frame_done, 1);
  endtask

  task automatic flat(input int v);
    fill(v, v, 0, 0);
    send_frame(8'd0, 8'd255);
  endtask

  task automatic check_reset_outputs();
    check("rst_frame_done", frame_done, 0);
    check("rst_frame_max", frame_max, 0);
    check("rst_alarm", alarm, 0);
    check("rst_beep_ack", beep_ack, 0);
    check("rst_tone_en", tone_en, 0);
    check("rst_tone_period", tone_period, 520000);
  endtask

  task automatic wait_ack(input string name);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_data);
      #1;
      if (beep_ack) begin got = 1; break; end
    end
    check(name, got, 1);
  endtask

  // Monitor: frame results against the scoreboard, alarm status one cycle later.
  exp_t cur;
  bit   pend = 0;
  always begin
    @(posedge clk_data);
    #1;
    if (beep_ack) ack_cnt++;
    if (pend) begin
      pend = 0;
      check("alarm", alarm, cur.alm);
      if (cur.alm) begin
        check("alarm_tone_en", tone_en, 1);
        check("alarm_tone_period", tone_period, 520000 - 2000 * int'(cur.mx));
      end
    end
    if (frame_done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_frame_done: got frame_max %0d expected no frame", frame_max);
      end else begin
        cur = exp_q.pop_front();
        check("frame_max", frame_max, cur.mx);
        pend = 1;
      end
    end
  end

  initial begin
    int a0, d0, pk;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (3) @(negedge clk_data);
    rst_n = 1'b1;

    // Single bright column, wide then narrowed window
    fill(50, 200, 10, 0);
    send_frame(8'd0, 8'd159);
    send_frame(8'd11, 8'd159);

    // Arming and a broken near streak
    repeat (3) flat(130);
    @(posedge clk_data);
    #1;
    check("alarm_rise", alarm, 1);
    check("alarm_rise_period", tone_period, 260000);
    repeat (5) flat(50);
    flat(130); flat(130); flat(90); flat(130); flat(50);

    // Release interrupted by a non-clear frame
    repeat (3) flat(130);
    flat(90); flat(90); flat(100);
    repeat (5) flat(90);

    // Randomized frames, windows and thresholds crossings
    for (int f = 0; f < 40; f++) begin
      case ($urandom_range(0, 5))
        0: pk = 50;
        1: pk = 90;
        2: pk = 100;
        3: pk = 130;
        4: pk = 200;
        default: pk = $urandom_range(0, 255);
      endcase
      fill($urandom_range(0, 80), pk, $urandom_range(0, FrameLast), 1);
      if ($urandom_range(0, 1) == 0) send_frame(8'd0, 8'd255);
      else send_frame(8'($urandom_range(0, 17)), 8'($urandom_range(0, 17)));
    end
    repeat (5) flat(0);

    // Plain beep
    @(negedge clk_data);
    beep_req = 1'b1;
    wait_ack("beep_ack_seen");
    check("beep_tone_en", tone_en, 1);
    check("beep_tone_period", tone_period, 200000);
    @(negedge clk_data);
    beep_req = 1'b0;
    a0 = ack_cnt;
    @(posedge clk_data);
    #1;
    check("beep_ack_single", beep_ack, 0);
    for (int k = 1; k <= 4; k++) begin
      flat(10);
      @(posedge clk_data);
      #1;
      check("beep_duration", tone_en, (k < 4) ? 1 : 0);
    end
    check("beep_period_hold", tone_period, 200000);
    @(negedge clk_data);
    check("beep_no_reack", ack_cnt, a0);

    // Alarm preempts a beep; held request granted after release
    beep_req = 1'b1;
    wait_ack("beep2_ack_seen");
    @(negedge clk_data);
    beep_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      flat(130);
      @(posedge clk_data);
      #1;
      check("beep2_still_on", tone_period, 200000);
    end
    flat(130);
    @(posedge clk_data);
    #1;
    check("preempt_alarm", alarm, 1);
    check("preempt_period", tone_period, 260000);
    @(negedge clk_data);
    beep_req = 1'b1;
    a0 = ack_cnt;
    repeat (5) flat(50);
    @(posedge clk_data);
    #1;
    check("release_alarm", alarm, 0);
    check("release_no_ack_yet", beep_ack, 0);
    @(posedge clk_data);
    #1;
    check("release_ack", beep_ack, 1);
    check("release_beep_period", tone_period, 200000);
    @(negedge clk_data);
    beep_req = 1'b0;
    check("release_ack_count", ack_cnt, a0 + 1);

    // Aborted frame, then reset mid-frame
    fill(20, 250, 3, 1);
    send_range(0, 12, 8'd0, 8'd255);
    fill(30, 240, 5, 1);
    send_range(0, 20, 8'd0, 8'd255);
    check("abort_no_done", frame_done, 0);
    @(negedge clk_data);
    d0 = done_cnt;
    rst_n = 1'b0;
    m_alarm = 0; near_run = 0; clear_run = 0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk_data);
    rst_n = 1'b1;
    send_range(21, FrameLast, 8'd0, 8'd255);
    repeat (5) @(negedge clk_data);
    check("no_done_after_reset", done_cnt, d0);
    fill(60, 140, 37, 1);
    send_frame(8'd2, 8'd9);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_data);
    repeat (3) @(negedge clk_data);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
